// File: rtl/uart_tx_arb.sv
// ============================================================================
// uart_tx_arb : round-robin arbiter sharing one UART transmitter among NumReq
//               valid/ready byte-stream requesters, one message per grant.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb #(
  parameter  int NumReq   = 4,
  parameter  int MaxBurst = 16,
  localparam int IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NumReq-1:0] i_req_valid,
  input  logic [8*NumReq-1:0] i_req_byte,
  input  logic [NumReq-1:0] i_req_last,
  output logic [NumReq-1:0] o_req_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_ready,
  output logic [IdW-1:0]    o_grant_id,
  output logic              o_busy
);

  localparam logic [7:0] c_max_burst = 8'(MaxBurst);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [IdW-1:0] last_id_q, last_id_d;
  logic [7:0]     burst_cnt_q, burst_cnt_d;

  logic           sel_found;
  logic [IdW-1:0] sel_id;
  logic           xfer;
  logic [7:0]     burst_nxt;

  // Round-robin search: first valid requester strictly after last_id, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(last_id_q) + i) % NumReq;
      if (!sel_found && i_req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    o_req_ready = '0;
    o_tx_valid  = 1'b0;
    o_tx_byte   = 8'd0;
    xfer        = 1'b0;
    burst_nxt   = (burst_cnt_q >= c_max_burst) ? burst_cnt_q : burst_cnt_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_id_d  = sel_id;
          burst_cnt_d = 8'd0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        o_tx_valid              = i_req_valid[grant_id_q];
        o_tx_byte               = i_req_byte[{grant_id_q, 3'b000} +: 8];
        o_req_ready[grant_id_q] = i_tx_ready;
        xfer                    = o_tx_valid && i_tx_ready;
        if (xfer) begin
          burst_cnt_d = burst_nxt;
          // Last byte and burst limit together still release only once.
          if (i_req_last[grant_id_q] || (burst_nxt == c_max_burst)) begin
            last_id_d = grant_id_q;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      last_id_q   <= IdW'(NumReq - 1);
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign o_busy     = (state_q == S_GRANT);
  assign o_grant_id = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// tb_uart_tx_arb : directed and randomized checks of uart_tx_arb against a
//                  message-level round-robin model.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int DEP = 64;

  logic            clk;
  logic            rstn;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_byte;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_valid;
  logic [7:0]      tx_byte;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;

  uart_tx_arb #(.NumReq(NR), .MaxBurst(MB)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_req_valid(req_valid),
    .i_req_byte (req_byte),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_tx_valid (tx_valid),
    .o_tx_byte  (tx_byte),
    .i_tx_ready (tx_ready),
    .o_grant_id (grant_id),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
    logic       rel;
  } xfer_t;

  // Per-requester pending bytes as {last, byte}.
  logic [8:0] mem [NR][DEP];
  int         head [NR];
  int         tail [NR];
  logic       en   [NR];
  xfer_t      exp_q[$];
  int         mdl_last;
  int         n_checks;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (en[k] && head[k] < tail[k]) begin
        req_valid[k]        = 1'b1;
        req_byte[8*k +: 8]  = mem[k][head[k]][7:0];
        req_last[k]         = mem[k][head[k]][8];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    if (head[k] == tail[k]) begin
      head[k] = 0;
      tail[k] = 0;
    end
    mem[k][tail[k]] = {l, b};
    tail[k]++;
  endtask

  task automatic add_msg(input int k, input int len);
    for (int j = 0; j < len; j++) push_byte(k, 8'($urandom), j == len - 1);
  endtask

  // Expected transfer order: visit requesters round-robin from the last owner,
  // each grant taking bytes up to the end of a message or MB bytes.
  task automatic build_exp();
    int   pos [NR];
    int   k, cnt;
    logic found, rel;
    logic [8:0] ent;
    exp_q.delete();
    for (int i = 0; i < NR; i++) pos[i] = head[i];
    while (1) begin
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= NR; i++) begin
        if (!found && pos[(mdl_last + i) % NR] < tail[(mdl_last + i) % NR]) begin
          found = 1'b1;
          k     = (mdl_last + i) % NR;
        end
      end
      if (!found) break;
      cnt = 0;
      rel = 1'b0;
      while (!rel) begin
        ent = mem[k][pos[k]];
        pos[k]++;
        cnt++;
        rel = ent[8] || (cnt == MB) || (pos[k] == tail[k]);
        exp_q.push_back('{id: 2'(k), b: ent[7:0], rel: rel});
      end
      mdl_last = k;
    end
  endtask

  // mode: 0 ready always, 1 random ready, 2 ready pulse every 20 cycles.
  task automatic run(input int mode, input int stall_at, input int bp_at, input int stop_n);
    int         n_x, cyc, stall_left, bp_left, stall_id;
    logic       rel_prev, idle_after_rel, xfer;
    logic [NR-1:0] took;
    xfer_t      e;
    n_x = 0; cyc = 0; stall_left = 0; bp_left = 0; stall_id = 0;
    rel_prev = 1'b0; idle_after_rel = 1'b0;
    build_exp();
    tx_ready = (mode == 1) ? 1'($urandom) : (mode == 0);
    drive();
    while (exp_q.size() > 0 && cyc < 5000 && (stop_n < 0 || n_x < stop_n)) begin
      @(negedge clk);
      cyc++;
      xfer = tx_valid && tx_ready;
      took = req_ready & req_valid;
      if (idle_after_rel) begin
        chk("regrant_after_one_idle", 32'(busy), 32'd1);
        idle_after_rel = 1'b0;
      end
      if (rel_prev) begin
        chk("release_idle", 32'(busy), 32'd0);
        rel_prev       = 1'b0;
        idle_after_rel = 1'b1;
      end
      if (!busy) chk("idle_outputs", 32'({tx_valid, req_ready, tx_byte}), 32'd0);
      else       chk("ready_only_granted", 32'(req_ready & ~(NR'(1) << grant_id)), 32'd0);
      if (stall_left > 0) begin
        chk("stall_tx_valid", 32'(tx_valid), 32'd0);
        chk("stall_hold", 32'({busy, grant_id}), 32'({1'b1, 2'(stall_id)}));
      end
      if (bp_left > 0) chk("bp_ready", 32'(req_ready), 32'd0);
      if (xfer) begin
        e = exp_q.pop_front();
        chk("xfer_id", 32'(grant_id), 32'(e.id));
        chk("xfer_byte", 32'(tx_byte), 32'(e.b));
        chk("xfer_ready", 32'(req_ready), 32'(NR'(1) << e.id));
        rel_prev = e.rel;
        n_x++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (took[k]) head[k]++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) en[stall_id] = 1'b1;
      end
      if (bp_left > 0) bp_left--;
      if (xfer && n_x == stall_at) begin
        stall_id     = int'(e.id);
        en[stall_id] = 1'b0;
        stall_left   = 50;
      end
      if (xfer && n_x == bp_at) bp_left = 100;
      if (bp_left > 0)    tx_ready = 1'b0;
      else if (mode == 0) tx_ready = 1'b1;
      else if (mode == 1) tx_ready = 1'($urandom);
      else                tx_ready = (cyc % 20 == 19);
      drive();
    end
    if (stop_n < 0) chk("run_complete", 32'(exp_q.size()), 32'd0);
    if (rel_prev) begin
      @(negedge clk);
      chk("release_idle", 32'(busy), 32'd0);
    end
    for (int k = 0; k < NR; k++) en[k] = 1'b1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    tx_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rstn     = 1'b1;
    mdl_last = NR - 1;
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      head[k] = 0;
      tail[k] = 0;
      en[k]   = 1'b1;
    end
    apply_reset();

    // Single requester, ready pulsing every 20 cycles.
    push_byte(2, 8'h23, 1'b0);
    push_byte(2, 8'h55, 1'b0);
    push_byte(2, 8'h3C, 1'b1);
    run(2, -1, -1, -1);

    // Contention from reset: all four send 2-byte messages.
    apply_reset();
    for (int k = 0; k < NR; k++) add_msg(k, 2);
    run(0, -1, -1, -1);

    // Burst limit splits requester 1's 6-byte message around requester 3.
    add_msg(1, 6);
    add_msg(3, 3);
    run(1, -1, -1, -1);

    // Granted requester stalls mid-message while requester 0 waits.
    add_msg(2, 3);
    add_msg(0, 2);
    run(0, 1, -1, -1);

    // Transmitter backpressure for 100 cycles inside a grant.
    add_msg(3, 5);
    add_msg(1, 2);
    run(0, -1, 3, -1);

    // Randomized traffic and readiness.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NR; k++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) add_msg(k, $urandom_range(1, 7));
      end
      run(1, -1, -1, -1);
    end

    // Reset after the 2nd byte of a 5-byte message.
    add_msg(2, 5);
    run(0, -1, -1, 2);
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    for (int k = 0; k < NR; k++) head[k] = tail[k];
    drive();
    @(negedge clk);
    rstn     = 1'b1;
    mdl_last = NR - 1;
    add_msg(2, 5);
    add_msg(0, 2);
    run(1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
